mux_param_pipe: RTL
===================

# mux_param_pipe

Registered N-way multiplexer with valid/ready handshaking: the parametrised successor to the plain combinational select mux. It sits between SIZE producer channels and a single consumer, for example wavefront or instruction-buffer ports feeding one issue slot. It forwards one beat per cycle through a single output register. Channel choice is either by an external select, or by an internal round-robin arbiter over the valid channels.

## Interface
- BITS, 2: select / channel-index width; SIZE ≤ 2^BITS
- SIZE, 4: number of input channels
- WIDTH, 1: data width per channel
- MODE, 0: 0 = external select, 1 = round-robin over `in_valid`

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  SIZE*WIDTH  channel i occupies [WIDTH*(i+1)-1 -: WIDTH]
- in_valid  in  SIZE  per-channel valid
- in_last  in  SIZE  per-channel last-beat flag; used only with MUX_PARAM_PIPE_LOCK_EN
- in_ready  out  SIZE  per-channel ready; at most one bit high
- select  in  BITS  channel choice; used in MODE 0 only
- out_data  out  WIDTH  registered data
- out_chan  out  BITS  index of the channel that supplied `out_data`
- out_valid  out  1  output register holds a beat
- out_ready  in  1  consumer accepts the beat

## Operation
- State:
  - Output register: `out_valid`, `out_data`, `out_chan`.
  - Round-robin pointer `ptr` [BITS].
  - With the macro only: `lock` and `lock_chan` [BITS].
- Reset state: `out_valid`=0, `out_data`=0, `out_chan`=0, `ptr`=0, `lock`=0, `lock_chan`=0.
- Load enable: `load = !out_valid | out_ready`.
- Grant `g` and grant-valid `gv`:
  - MODE 0: `g = select`. `gv = (select < SIZE)`. A select value ≥ SIZE grants nothing, and all `in_ready` bits are 0.
  - MODE 1: `g` is the first channel with `in_valid` set, searching `ptr`, `ptr+1`, … with wrap at SIZE back to 0. `gv = |in_valid`.
- `in_ready[g] = load & gv`. All other `in_ready` bits are 0.
- Transfer condition: `xfer = in_valid[g] & in_ready[g]`.
- On `xfer`:
  - `out_data` ← channel g data, `out_chan` ← g, `out_valid` ← 1.
  - In MODE 1, `ptr` ← g+1, or 0 when g = SIZE-1.
- On `load & !xfer`: `out_valid` ← 0. `out_data` and `out_chan` hold their previous values.
- On `!load`: everything holds. Data is stable while `out_valid & !out_ready`.
- MODE 0 ignores `ptr`; it stays at 0.

## Timing
- Latency: one cycle from input handshake to `out_valid`.
- Throughput: one beat per cycle when `out_ready` is held at 1.
- Combinational paths:
  - `out_ready` → `in_ready`.
  - `in_valid`/`select` → `in_ready`.
  - No path from `in_*` to `out_*`.
- Simultaneous drain and fill (`out_valid & out_ready & xfer`): the new beat replaces the old one in the same edge, with no bubble.
- A change of `select` takes effect in the same cycle. A beat already held in the output register is unaffected.
- Reset asserted mid-operation clears all state immediately; any beat in flight is dropped. After `rst_n` deasserts, the first grant in MODE 1 is searched from channel 0.

## Configuration
- Macro: `MUX_PARAM_PIPE_LOCK_EN`.
- With the macro defined (packet lock):
  - A transfer with `in_last[g]`=0 sets `lock`=1 and `lock_chan`=g.
  - While `lock`=1, g is forced to `lock_chan` in both modes, and `gv`=1. `select` and the arbiter are ignored.
  - A transfer with `in_last[lock_chan]`=1 clears `lock`.
  - In MODE 1, `ptr` advances only on a transfer whose `in_last` is 1.
- With the macro undefined: `in_last` is ignored, arbitration is per beat, and the lock logic is absent.

## Test plan
- Reset default: assert `rst_n`=0 with random inputs → `out_valid`=0, `out_data`=0, `out_chan`=0, `in_ready`=0.
- MODE 0, SIZE=4, WIDTH=8, data {D3..D0}={0x44,0x33,0x22,0x11}, all valid, select=2, `out_ready`=1 → `in_ready`=4'b0100; next cycle `out_data`=0x33, `out_chan`=2. With select=5 (BITS=3) → `in_ready`=0 and `out_valid` falls after the drain.
- Backpressure: hold `out_ready`=0 after one beat → `in_ready`=0 and `out_data` stable for 5 cycles. Release → the next beat loads in the same cycle as the drain, with no bubble.
- MODE 1, all four channels continuously valid → `out_chan` sequence 0,1,2,3,0. With only channels 1 and 3 valid → 1,3,1,3.
- MODE 1 wrap: `ptr`=3 and only channel 0 valid → grant 0, then `ptr`=1.
- With `MUX_PARAM_PIPE_LOCK_EN`, MODE 1: channel 1 sends 3 beats with `in_last`=0,0,1 while channel 2 is valid → `out_chan`=1,1,1 then 2.

Source files
------------

// File: rtl/mux_param_pipe.sv
// Registered N-way mux with valid/ready handshake; channel chosen by external select
// (MODE 0) or round-robin over in_valid (MODE 1). Packet lock: MUX_PARAM_PIPE_LOCK_EN.
module mux_param_pipe #(
  parameter int BITS  = 2,
  parameter int SIZE  = 4,
  parameter int WIDTH = 1,
  parameter int MODE  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SIZE*WIDTH-1:0] in_data,
  input  logic [SIZE-1:0]       in_valid,
  input  logic [SIZE-1:0]       in_last,
  output logic [SIZE-1:0]       in_ready,
  input  logic [BITS-1:0]       select,
  output logic [WIDTH-1:0]      out_data,
  output logic [BITS-1:0]       out_chan,
  output logic                  out_valid,
  input  logic                  out_ready
);
  localparam int NCH = 1 << BITS;

  logic [WIDTH-1:0] w_data_ext [NCH];
  logic [NCH-1:0]   w_valid_ext;
  logic [NCH-1:0]   w_ready_ext;
  logic [BITS-1:0]  w_rr_grant;
  logic [BITS-1:0]  w_grant;
  logic             w_gv;
  logic             w_load;
  logic             w_xfer;
  logic             w_ptr_adv;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [BITS-1:0]  r_out_chan;
  logic [BITS-1:0]  r_ptr;

  // Channels are padded to 2^BITS so any BITS-wide grant indexes a real entry;
  // padded entries are never valid, so an out-of-range select cannot transfer.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ext
    if (gi < SIZE) begin : g_chan
      assign w_data_ext[gi] = in_data[WIDTH*(gi+1)-1 -: WIDTH];
    end else begin : g_pad
      assign w_data_ext[gi] = '0;
    end
  end
  assign w_valid_ext = NCH'(in_valid);

`ifdef MUX_PARAM_PIPE_LOCK_EN
  logic [NCH-1:0]  w_last_ext;
  logic            r_lock;
  logic [BITS-1:0] r_lock_chan;
  assign w_last_ext = NCH'(in_last);
  assign w_ptr_adv  = w_last_ext[w_grant];
`else
  logic w_unused_last;
  assign w_unused_last = ^in_last;
  assign w_ptr_adv     = 1'b1;
`endif

  // Scan from the far end so the last hit is the first valid channel at or after ptr.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_rr_grant = r_ptr;
    for (int k = SIZE - 1; k >= 0; k--) begin
      if (w_valid_ext[BITS'((int'(r_ptr) + k) % SIZE)])
        w_rr_grant = BITS'((int'(r_ptr) + k) % SIZE);
    end
  end

  always_comb begin
    w_grant = w_rr_grant;
    w_gv    = |in_valid;
    if (MODE == 0) begin
      w_grant = select;
      w_gv    = int'(select) < SIZE;
    end
`ifdef MUX_PARAM_PIPE_LOCK_EN
    if (r_lock) begin
      w_grant = r_lock_chan;
      w_gv    = 1'b1;
    end
`endif
  end

  assign w_load = !r_out_valid | out_ready;

  // Ready is held low while reset is asserted so no producer sees a phantom accept.
  always_comb begin
    w_ready_ext          = '0;
    w_ready_ext[w_grant] = w_load & w_gv & rst_n;
  end

  assign in_ready = w_ready_ext[SIZE-1:0];
  assign w_xfer   = w_valid_ext[w_grant] & w_ready_ext[w_grant];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
    end else if (w_load) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_out_valid <= w_xfer;
      if (w_xfer) begin
        r_out_data <= w_data_ext[w_grant];
        r_out_chan <= w_grant;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (MODE != 0 && w_xfer && w_ptr_adv) begin
      r_ptr <= (int'(w_grant) == SIZE - 1) ? '0 : w_grant + BITS'(1);
    end
  end

`ifdef MUX_PARAM_PIPE_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock      <= 1'b0;
      r_lock_chan <= '0;
    end else if (w_xfer) begin
      r_lock <= !w_last_ext[w_grant];
      if (!w_last_ext[w_grant]) r_lock_chan <= w_grant;
    end
  end
`endif

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;

endmodule
